// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel/control types for the framebuffer scheduler.
package vga_pkg;

  // 640x480@60 defaults
  localparam int unsigned H_DISPLAY_DEF   = 640;
  localparam int unsigned H_FPORCH_DEF    = 16;
  localparam int unsigned H_SYNCPULSE_DEF = 96;
  localparam int unsigned H_BPORCH_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF   = 480;
  localparam int unsigned V_FPORCH_DEF    = 10;
  localparam int unsigned V_SYNCPULSE_DEF = 2;
  localparam int unsigned V_BPORCH_DEF    = 33;

  localparam int unsigned H_TOTAL  = H_DISPLAY_DEF + H_FPORCH_DEF + H_SYNCPULSE_DEF + H_BPORCH_DEF;
  localparam int unsigned V_TOTAL  = V_DISPLAY_DEF + V_FPORCH_DEF + V_SYNCPULSE_DEF + V_BPORCH_DEF;
  localparam int unsigned FB_WORDS = H_DISPLAY_DEF * V_DISPLAY_DEF;

  // One framebuffer word: {r,g,b}
  typedef logic [2:0] rgb_t;

  // Per-pixel control flags carried down the output pipeline alongside the RAM access
  typedef struct packed {
    logic de;  // visible pixel
    logic hs;  // hsync active (polarity applied at the pins)
    logic vs;  // vsync active
    logic fs;  // pixel (0,0)
  } vid_ctl_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with region decode at the counter stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = H_DISPLAY_DEF,
  parameter int unsigned H_FPORCH    = H_FPORCH_DEF,
  parameter int unsigned H_SYNCPULSE = H_SYNCPULSE_DEF,
  parameter int unsigned H_BPORCH    = H_BPORCH_DEF,
  parameter int unsigned V_DISPLAY   = V_DISPLAY_DEF,
  parameter int unsigned V_FPORCH    = V_FPORCH_DEF,
  parameter int unsigned V_SYNCPULSE = V_SYNCPULSE_DEF,
  parameter int unsigned V_BPORCH    = V_BPORCH_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic de_o,
  output logic hsync_act_o,
  output logic vsync_act_o,
  output logic frame_first_o,
  output logic frame_last_o
);

  localparam int unsigned HTotal = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH;
  localparam int unsigned VTotal = V_DISPLAY + V_FPORCH + V_SYNCPULSE + V_BPORCH;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0] HDisp   = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HsStart = HW'(H_DISPLAY + H_FPORCH);
  localparam logic [HW-1:0] HsEnd   = HW'(H_DISPLAY + H_FPORCH + H_SYNCPULSE);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0] VDisp   = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VsStart = VW'(V_DISPLAY + V_FPORCH);
  localparam logic [VW-1:0] VsEnd   = VW'(V_DISPLAY + V_FPORCH + V_SYNCPULSE);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  // Next raster position: h wraps every line, v advances on h wrap and wraps per frame
  always_comb begin
    h_last = (h_q == HLast);
    v_last = (v_q == VLast);
    h_d    = h_q + HW'(1);
    v_d    = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  // Raster position registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Region decode for the current counter stage
  always_comb begin
    de_o          = (h_q < HDisp) && (v_q < VDisp);
    hsync_act_o   = (h_q >= HsStart) && (h_q < HsEnd);
    vsync_act_o   = (v_q >= VsStart) && (v_q < VsEnd);
    frame_first_o = (h_q == '0) && (v_q == '0);
    frame_last_o  = h_last && v_last;
  end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM scheduler: one read per visible pixel, writer granted only in blanking,
// and a 3-stage output pipeline that keeps colour and sync aligned at the VGA pins.
module vga_fb_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = H_DISPLAY_DEF,
  parameter int unsigned H_FPORCH    = H_FPORCH_DEF,
  parameter int unsigned H_SYNCPULSE = H_SYNCPULSE_DEF,
  parameter int unsigned H_BPORCH    = H_BPORCH_DEF,
  parameter int unsigned V_DISPLAY   = V_DISPLAY_DEF,
  parameter int unsigned V_FPORCH    = V_FPORCH_DEF,
  parameter int unsigned V_SYNCPULSE = V_SYNCPULSE_DEF,
  parameter int unsigned V_BPORCH    = V_BPORCH_DEF,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic              hsync,
  output logic              vsync,
  output logic              r,
  output logic              g,
  output logic              b,
  output logic              frame_start
);

  localparam int unsigned FbWords = H_DISPLAY * V_DISPLAY;

  // Counter-stage signals
  logic de_c, hs_act_c, vs_act_c, first_c, last_c;

  vga_timing #(
    .H_DISPLAY  (H_DISPLAY),
    .H_FPORCH   (H_FPORCH),
    .H_SYNCPULSE(H_SYNCPULSE),
    .H_BPORCH   (H_BPORCH),
    .V_DISPLAY  (V_DISPLAY),
    .V_FPORCH   (V_FPORCH),
    .V_SYNCPULSE(V_SYNCPULSE),
    .V_BPORCH   (V_BPORCH)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (rst),
    .de_o         (de_c),
    .hsync_act_o  (hs_act_c),
    .vsync_act_o  (vs_act_c),
    .frame_first_o(first_c),
    .frame_last_o (last_c)
  );

  // Read address walks the visible pixels linearly, so no v*H_DISPLAY product is needed
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  // Stage 1: RAM command and write handshake
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  rgb_t              mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              grant, wr_in_range;

  // Control flags delayed alongside the RAM access
  vid_ctl_t ctl_c, ctl_s1_q, ctl_s2_q;

  // Stage 3: registered pin outputs
  rgb_t rgb_q, rgb_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic fs_q, fs_d;

  // Slot arbitration: display reads win; the writer takes blanking slots, never two acks in a row
  always_comb begin
    grant       = ~de_c & wr_req & ~wr_ack_q;
    wr_in_range = (wr_addr < ADDR_W'(FbWords));
    wr_ack_d    = grant;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (de_c) begin
      mem_addr_d = rd_addr_q;
    end else if (grant && wr_in_range) begin
      // Out-of-range requests are acked but dropped, leaving the RAM port idle
      mem_addr_d  = wr_addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = wr_data;
    end
  end

  // Read address: advance after each visible read, restart for pixel (0,0)
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (last_c) begin
      rd_addr_d = '0;
    end else if (de_c) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
  end

  // Output stage: colour gated by the delayed display enable, sync polarity applied here
  always_comb begin
    ctl_c   = '{de: de_c, hs: hs_act_c, vs: vs_act_c, fs: first_c};
    rgb_d   = ctl_s2_q.de ? rgb_t'(mem_rdata) : rgb_t'('0);
    hsync_d = ctl_s2_q.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = ctl_s2_q.vs ? SYNC_POL : ~SYNC_POL;
    fs_d    = ctl_s2_q.fs;
  end

  // Pipeline and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      ctl_s1_q    <= '0;
      ctl_s2_q    <= '0;
      rgb_q       <= '0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      fs_q        <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      ctl_s1_q    <= ctl_c;
      ctl_s2_q    <= ctl_s1_q;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign r           = rgb_q[2];
  assign g           = rgb_q[1];
  assign b           = rgb_q[0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler on a reduced raster (28x13 total, 16x6 visible) so whole
// frames fit in a short run. hsync active h in [19,24), vsync active v in [8,11), frame = 364.
module tb_vga_fb_scheduler;

  localparam int unsigned HD = 16;
  localparam int unsigned HT = 28;
  localparam int unsigned VD = 6;
  localparam int unsigned FT = 364;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        hsync, vsync, r, g, b, frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_low = 0;
  int vs_low = 0;
  int fs_cnt = 0;
  logic load_ram = 1'b0;

  always #5 clk = ~clk;

  vga_fb_scheduler #(
    .H_DISPLAY  (16),
    .H_FPORCH   (3),
    .H_SYNCPULSE(5),
    .H_BPORCH   (4),
    .V_DISPLAY  (6),
    .V_FPORCH   (2),
    .V_SYNCPULSE(3),
    .V_BPORCH   (2),
    .SYNC_POL   (1'b0),
    .ADDR_W     (19)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hsync      (hsync),
    .vsync      (vsync),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_start(frame_start)
  );

  // Synchronous-read RAM, preloaded with addr[2:0]
  logic [2:0] ram [0:127];
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 128; i++) ram[i] <= 3'(i);
    end else begin
      mem_rdata <= ram[7'(mem_addr)];
      if (mem_we) ram[7'(mem_addr)] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected {r,g,b,hsync,vsync,frame_start} at output cycle c (c counts from the reset edge)
  function automatic logic [5:0] exp_vid(input int c, input bit ovr);
    int s, h, v;
    logic [2:0] pix;
    bit de;
    if (c < 3) return 6'b000_110;
    s = (c - 3) % FT;
    h = s % HT;
    v = s / HT;
    de = (h < HD) && (v < VD);
    pix = 3'(v * HD + h);
    if (ovr && v == 0 && h == 5) pix = 3'b010;
    if (ovr && v == 0 && h == 6) pix = 3'b011;
    if (ovr && v == 0 && h == 7) pix = 3'b100;
    return {de ? pix : 3'b000, !(h >= 19 && h < 24), !(v >= 8 && v < 11), (h == 0 && v == 0)};
  endfunction

  // Video pins plus the read address issued for the previous counter stage
  task automatic check_video(input bit ovr);
    int p, h, v;
    chk("video", {26'd0, r, g, b, hsync, vsync, frame_start}, {26'd0, exp_vid(cyc, ovr)});
    if (cyc == 0) begin
      chk("mem_addr_rst", {13'd0, mem_addr}, 32'd0);
    end else begin
      p = (cyc - 1) % FT;
      h = p % HT;
      v = p / HT;
      if (h < HD && v < VD) chk("rd_addr", {13'd0, mem_addr}, 32'(v * HD + h));
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_req = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    load_ram = 1'b1;
    step();
    load_ram = 1'b0;
    step();
    // Reset edge just taken: counter stage (0,0) is now cycle 0
    cyc = 0;
    rst = 1'b0;
    chk("rst_ack_we", {30'd0, wr_ack, mem_we}, 32'd0);

    // Frame 1, no writes
    while (cyc <= 367) begin
      check_video(1'b0);
      chk("idle_ack_we", {30'd0, wr_ack, mem_we}, 32'd0);
      if (cyc >= 3 && cyc <= 366) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (cyc >= 3 && frame_start) fs_cnt++;
      step();
    end
    chk("hsync_low_cycles", 32'(hs_low), 32'd65);
    chk("vsync_low_cycles", 32'(vs_low), 32'd84);
    chk("frame_start_count", 32'(fs_cnt), 32'd2);

    // Request raised at h=5 of line 0 (visible): held until the first blanking slot at h=16
    step();
    wr_req = 1'b1;
    wr_addr = 19'd5;
    wr_data = 3'b010;
    while (cyc <= 381) begin
      chk("held_ack", {31'd0, wr_ack}, {31'd0, cyc == 381});
      chk("held_we", {31'd0, mem_we}, {31'd0, cyc == 381});
      if (cyc == 381) begin
        chk("held_addr", {13'd0, mem_addr}, 32'd5);
        chk("held_wdata", {29'd0, mem_wdata}, 32'd2);
        wr_req = 1'b0;
      end
      step();
    end

    // Out-of-range address in blanking: acked, not written
    chk("oor_pre_ack", {31'd0, wr_ack}, 32'd0);
    wr_req = 1'b1;
    wr_addr = 19'd96;
    wr_data = 3'b111;
    step();
    chk("oor_ack", {31'd0, wr_ack}, 32'd1);
    chk("oor_we", {31'd0, mem_we}, 32'd0);
    chk("oor_addr_hold", {13'd0, mem_addr}, 32'd5);
    wr_req = 1'b0;
    step();

    // Back-to-back requests in blanking: second is granted one cycle after the first ack
    chk("b2b_pre_ack", {31'd0, wr_ack}, 32'd0);
    wr_req = 1'b1;
    wr_addr = 19'd6;
    wr_data = 3'b011;
    step();
    chk("b2b_ack1", {30'd0, wr_ack, mem_we}, 32'd3);
    chk("b2b_addr1", {10'd0, mem_wdata, mem_addr}, {10'd0, 3'b011, 19'd6});
    wr_addr = 19'd7;
    wr_data = 3'b100;
    step();
    chk("b2b_gap", {30'd0, wr_ack, mem_we}, 32'd0);
    step();
    chk("b2b_ack2", {30'd0, wr_ack, mem_we}, 32'd3);
    chk("b2b_addr2", {10'd0, mem_wdata, mem_addr}, {10'd0, 3'b100, 19'd7});
    wr_req = 1'b0;
    step();
    chk("b2b_post_ack", {31'd0, wr_ack}, 32'd0);

    // Frame 3, line 0: written pixels 5..7 read back, frame_start on (0,0)
    while (cyc < 731) step();
    while (cyc <= 746) begin
      check_video(1'b1);
      step();
    end

    // Reset for one cycle at h=20 (blanking) with a request pending: no ack, clean restart
    while (cyc < 748) step();
    rst = 1'b1;
    wr_req = 1'b1;
    wr_addr = 19'd9;
    wr_data = 3'b001;
    step();
    cyc = 0;
    rst = 1'b0;
    wr_req = 1'b0;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    while (cyc <= 60) begin
      check_video(1'b1);
      chk("mid_rst_ack", {31'd0, wr_ack}, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
